// File: rtl/tran_pkg.sv
// Purpose: shared types and constants for the tran_deframer slice.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, err_code values, default sync byte.
package tran_pkg;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_LEN  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CHK  = 2'd3
   } tran_state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/tran_gap_timer.sv
// Purpose: counts idle cycles inside a frame and flags when the gap limit is hit.
// Latency: expire is combinational from the registered count and cnt_en.
// Backpressure: none; driven every cycle by the deframer FSM.
// Ports: clk, reset_n (async active-low), clr (zero the count), cnt_en (idle
//        cycle inside a frame), expire (this idle cycle is number TIMEOUT-1).
module tran_gap_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic cnt_en,
   output logic expire
);

   localparam int unsigned GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [GW-1:0] gap_q;
   logic [GW-1:0] gap_d;

   // gap_q holds idle cycles already seen, so the idle cycle that brings the
   // count to TIMEOUT-1 is the one where gap_q still reads TIMEOUT-2.
   assign expire = cnt_en && (gap_q == GW'(TIMEOUT - 2));

   always_comb begin
      gap_d = gap_q;
      if (clr) begin
         gap_d = '0;
      end else if (cnt_en) begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end

endmodule

// File: rtl/tran_deframer.sv
// Purpose: hunts sync byte, reads length, forwards payload, checks XOR checksum.
// Latency: every output is registered, one cycle after the causing data_en.
// Backpressure: none; each data_en byte is consumed in the cycle presented.
// Ports: clk, reset_n, data_in/data_en (byte stream in), clear (sync abort),
//        pay_data/pay_valid/pay_sop/pay_eop (payload out), frame_ok/frame_err
//        (per-frame pulses), err_code (last error), frame_cnt (good frames).
module tran_deframer
   import tran_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_en,
   input  logic       clear,
   output logic [7:0] pay_data,
   output logic       pay_valid,
   output logic       pay_sop,
   output logic       pay_eop,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] frame_cnt
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   tran_state_t state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  pay_data_q, pay_data_d;
   logic        pay_valid_q, pay_valid_d;
   logic        pay_sop_q, pay_sop_d;
   logic        pay_eop_q, pay_eop_d;
   logic        frame_ok_q, frame_ok_d;
   logic        frame_err_q, frame_err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic gap_clr;
   logic gap_cnt_en;
   logic gap_expire;

   // Timer idles at zero in HUNT, so entering LEN always starts from zero.
   assign gap_clr    = clear || data_en || (state_q == ST_HUNT);
   assign gap_cnt_en = !gap_clr;

   tran_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (gap_clr),
      .cnt_en  (gap_cnt_en),
      .expire  (gap_expire)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      csum_d      = csum_q;
      rem_d       = rem_q;
      pay_data_d  = pay_data_q;
      pay_valid_d = 1'b0;
      pay_sop_d   = 1'b0;
      pay_eop_d   = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      frame_cnt_d = frame_cnt_q;

      if (clear) begin
         state_d = ST_HUNT;
      end else if (gap_expire) begin
         // expire only fires on an idle in-frame cycle, so no byte is lost here
         frame_err_d = 1'b1;
         err_code_d  = ERR_TMO;
         state_d     = ST_HUNT;
      end else if (data_en) begin
         case (state_q)
            ST_HUNT: begin
               if (data_in == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
               if (data_in == 8'd0 || data_in > MAX_LEN_B) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = ST_HUNT;
               end else begin
                  len_d   = data_in;
                  csum_d  = data_in;
                  rem_d   = data_in;
                  state_d = ST_PAY;
               end
            end
            ST_PAY: begin
               pay_data_d  = data_in;
               pay_valid_d = 1'b1;
               pay_sop_d   = (rem_q == len_q);
               pay_eop_d   = (rem_q == 8'd1);
               csum_d      = csum_q ^ data_in;
               rem_d       = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = ST_CHK;
            end
            ST_CHK: begin
               if (data_in == csum_q) begin
                  frame_ok_d  = 1'b1;
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  err_code_d  = ERR_NONE;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
               state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_HUNT;
         len_q       <= '0;
         csum_q      <= '0;
         rem_q       <= '0;
         pay_data_q  <= '0;
         pay_valid_q <= 1'b0;
         pay_sop_q   <= 1'b0;
         pay_eop_q   <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         csum_q      <= csum_d;
         rem_q       <= rem_d;
         pay_data_q  <= pay_data_d;
         pay_valid_q <= pay_valid_d;
         pay_sop_q   <= pay_sop_d;
         pay_eop_q   <= pay_eop_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pay_data  = pay_data_q;
   assign pay_valid = pay_valid_q;
   assign pay_sop   = pay_sop_q;
   assign pay_eop   = pay_eop_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tran_deframer.sv
// Purpose: directed-vector bench for tran_deframer with a frame-level model.
// Latency: expects every response one cycle after the input that caused it.
// Backpressure: none; stimulus presents one byte or idle per cycle.
module tb_tran_deframer;

   localparam int SYNC    = 8'hA5;
   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_en = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] pay_data;
   logic       pay_valid, pay_sop, pay_eop, frame_ok, frame_err;
   logic [1:0] err_code;
   logic [7:0] frame_cnt;

   int errors = 0;
   int checks = 0;

   tran_deframer #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in),
      .data_en   (data_en),
      .clear     (clear),
      .pay_data  (pay_data),
      .pay_valid (pay_valid),
      .pay_sop   (pay_sop),
      .pay_eop   (pay_eop),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- frame-level model ----------------
   // Bytes after the sync byte are collected in a queue; the role of each byte
   // follows from its position and the length byte at the head of the queue.
   bit         m_in_frame;
   logic [7:0] m_q[$];
   int         m_idle;
   int         m_cnt;
   int         m_code;
   int         e_valid, e_sop, e_eop, e_ok, e_err, e_data;

   task automatic model_reset();
      m_in_frame = 0;
      m_q.delete();
      m_idle = 0;
      m_cnt = 0;
      m_code = 0;
      e_valid = 0; e_sop = 0; e_eop = 0; e_ok = 0; e_err = 0; e_data = 0;
   endtask

   task automatic model_abort(input int code);
      e_err = 1;
      m_code = code;
      m_in_frame = 0;
      m_q.delete();
   endtask

   task automatic model_step(input bit en, input logic [7:0] d, input bit clr);
      int len;
      int x;
      e_valid = 0; e_sop = 0; e_eop = 0; e_ok = 0; e_err = 0;
      if (clr) begin
         m_in_frame = 0;
         m_q.delete();
         m_idle = 0;
      end else if (!m_in_frame) begin
         if (en && d == 8'(SYNC)) begin
            m_in_frame = 1;
            m_q.delete();
            m_idle = 0;
         end
      end else if (!en) begin
         m_idle++;
         if (m_idle == TIMEOUT - 1) model_abort(3);
      end else begin
         m_idle = 0;
         m_q.push_back(d);
         len = int'(m_q[0]);
         if (m_q.size() == 1) begin
            if (len == 0 || len > MAX_LEN) model_abort(1);
         end else if (m_q.size() <= len + 1) begin
            e_valid = 1;
            e_data  = int'(d);
            e_sop   = (m_q.size() == 2) ? 1 : 0;
            e_eop   = (m_q.size() == len + 1) ? 1 : 0;
         end else begin
            x = 0;
            for (int i = 0; i < m_q.size() - 1; i++) x = x ^ int'(m_q[i]);
            if (x == int'(d)) begin
               e_ok = 1;
               m_cnt = (m_cnt + 1) % 256;
               m_code = 0;
               m_in_frame = 0;
               m_q.delete();
            end else begin
               model_abort(2);
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input bit with_data);
      chk("pay_valid", 32'(pay_valid), e_valid);
      chk("pay_sop",   32'(pay_sop),   e_sop);
      chk("pay_eop",   32'(pay_eop),   e_eop);
      chk("frame_ok",  32'(frame_ok),  e_ok);
      chk("frame_err", 32'(frame_err), e_err);
      chk("err_code",  32'(err_code),  m_code);
      chk("frame_cnt", 32'(frame_cnt), m_cnt);
      if (with_data || e_valid != 0) chk("pay_data", 32'(pay_data), e_data);
      chk("ok_err_excl", 32'(frame_ok & frame_err), 0);
      chk("valid_pulse_excl", 32'(pay_valid & (frame_ok | frame_err)), 0);
   endtask

   // Inputs change 1ns after the edge; outputs are compared at that same point,
   // after the edge that registered the response.
   task automatic step(input bit en, input logic [7:0] d, input bit clr);
      data_en = en;
      data_in = d;
      clear   = clr;
      @(posedge clk);
      model_step(en, d, clr);
      #1;
      data_en = 1'b0;
      clear   = 1'b0;
      check_all(1'b0);
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all(1'b1);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      do_reset();
      chk("reset_cnt_lit", 32'(frame_cnt), 0);

      // good frame: checksum 03^11^22^33 = 03
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      idle(2);
      chk("t1_cnt_lit", 32'(frame_cnt), 1);
      chk("t1_model_cnt_lit", m_cnt, 1);

      // bad checksum: 02^10^20 = 32, 31 sent
      send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
      idle(1);
      chk("t2_code_lit", 32'(err_code), 2);
      chk("t2_cnt_lit", 32'(frame_cnt), 1);

      // leading junk dropped, sync value as payload: 01^A5 = A4
      send(8'h00); send(8'h7F); send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
      idle(1);
      chk("t3_cnt_lit", 32'(frame_cnt), 2);
      chk("t3_code_lit", 32'(err_code), 0);

      // length limits
      send(8'hA5); send(8'h00);
      chk("t4_len0_code_lit", 32'(err_code), 1);
      idle(1);
      send(8'hA5); send(8'h11);
      chk("t4_len17_code_lit", 32'(err_code), 1);
      idle(1);
      // largest legal length, payload 1..16: XOR(1..16)=10, ^ len 10 = 00
      send(8'hA5); send(8'h10);
      for (int i = 1; i <= 16; i++) send(8'(i));
      send(8'h00);
      chk("t4_max_cnt_lit", 32'(frame_cnt), 3);

      // longest legal gap: byte on idle slot TIMEOUT-1 accepted; 02^55^66 = 31
      send(8'hA5); send(8'h02); send(8'h55);
      idle(TIMEOUT - 2);
      send(8'h66); send(8'h31);
      chk("t5_gap_ok_cnt_lit", 32'(frame_cnt), 4);
      // one more idle cycle times the frame out
      send(8'hA5); send(8'h02); send(8'h55);
      idle(TIMEOUT - 1);
      idle(1);
      chk("t5_tmo_code_lit", 32'(err_code), 3);

      // clear with a byte present mid-payload: silent abort
      send(8'hA5); send(8'h03); send(8'h01);
      step(1'b1, 8'h02, 1'b1);
      idle(2);
      send(8'h04);
      chk("t6_clear_code_lit", 32'(err_code), 3);
      chk("t6_clear_cnt_lit", 32'(frame_cnt), 4);

      // async reset mid-frame
      send(8'hA5); send(8'h02); send(8'h01);
      do_reset();
      chk("t7_rst_code_lit", 32'(err_code), 0);
      send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
      idle(1);
      chk("t7_post_cnt_lit", 32'(frame_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog at %0t: bench did not complete", $time);
      $fatal(1, "watchdog");
   end

endmodule
